// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-requester memory arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        DONE
    } state_e;

    typedef enum logic {
        REQ_CORE = 1'b0,
        REQ_DBG  = 1'b1
    } req_e;

    localparam int MEM_LAT_MIN = 1;
    localparam int MEM_LAT_MAX = 4;
    localparam int CNT_W       = 2;

    // Latency counter load value; out-of-range latencies are clamped to the legal window.
    function automatic logic [CNT_W-1:0] lat_load(input int lat);
        int v;
        v = lat;
        if (v < MEM_LAT_MIN) v = MEM_LAT_MIN;
        if (v > MEM_LAT_MAX) v = MEM_LAT_MAX;
        v = v - 1;
        return v[CNT_W-1:0];
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Combinational two-way round-robin picker: on contention the side not granted last wins.
module rr_arb2
    import mem_arb_pkg::*;
(
    input  logic elig_core,
    input  logic elig_dbg,
    input  req_e last_grant,
    output logic valid,
    output req_e winner
);

    always_comb begin
        valid  = elig_core | elig_dbg;
        winner = REQ_CORE;
        if (elig_core && elig_dbg) begin
            winner = (last_grant == REQ_CORE) ? REQ_DBG : REQ_CORE;
        end else if (elig_dbg) begin
            winner = REQ_DBG;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates a core and a debug/loader port onto one single-port memory,
// one non-preemptive access at a time, with core halt support and a core stall counter.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int MEM_LAT = 1,
    parameter int AW      = 32,
    parameter int DW      = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          core_req,
    input  logic          core_we,
    input  logic [AW-1:0] core_addr,
    input  logic [DW-1:0] core_wdata,
    output logic          core_ack,
    output logic [DW-1:0] core_rdata,
    input  logic          dbg_req,
    input  logic          dbg_we,
    input  logic [AW-1:0] dbg_addr,
    input  logic [DW-1:0] dbg_wdata,
    output logic          dbg_ack,
    output logic [DW-1:0] dbg_rdata,
    input  logic          halt_req,
    output logic          halted,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic [31:0]   stall_cnt
);

    localparam logic [CNT_W-1:0] LAT_LOAD = lat_load(MEM_LAT);

    state_e            state_reg, state_next;
    req_e              grant_reg, grant_next;
    logic              we_reg, we_next;
    logic [AW-1:0]     addr_reg, addr_next;
    logic [DW-1:0]     wdata_reg, wdata_next;
    logic [CNT_W-1:0]  cnt_reg, cnt_next;
    logic [DW-1:0]     core_rdata_reg, core_rdata_next;
    logic [DW-1:0]     dbg_rdata_reg, dbg_rdata_next;
    logic [31:0]       stall_reg, stall_next;
    logic              halted_reg, halted_next;
    logic              capture;
    logic              pick_valid;
    req_e              pick_winner;

    rr_arb2 u_rr_arb2 (
        .elig_core  (core_req & ~halt_req),
        .elig_dbg   (dbg_req),
        .last_grant (grant_reg),
        .valid      (pick_valid),
        .winner     (pick_winner)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg      <= IDLE;
            grant_reg      <= REQ_DBG;
            we_reg         <= 1'b0;
            addr_reg       <= '0;
            wdata_reg      <= '0;
            cnt_reg        <= '0;
            core_rdata_reg <= '0;
            dbg_rdata_reg  <= '0;
            stall_reg      <= '0;
            halted_reg     <= 1'b0;
        end else begin
            state_reg      <= state_next;
            grant_reg      <= grant_next;
            we_reg         <= we_next;
            addr_reg       <= addr_next;
            wdata_reg      <= wdata_next;
            cnt_reg        <= cnt_next;
            core_rdata_reg <= core_rdata_next;
            dbg_rdata_reg  <= dbg_rdata_next;
            stall_reg      <= stall_next;
            halted_reg     <= halted_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        grant_next      = grant_reg;
        we_next         = we_reg;
        addr_next       = addr_reg;
        wdata_next      = wdata_reg;
        cnt_next        = cnt_reg;
        core_rdata_next = core_rdata_reg;
        dbg_rdata_next  = dbg_rdata_reg;
        capture         = 1'b0;

        case (state_reg)
            IDLE: begin
                if (pick_valid) begin
                    grant_next = pick_winner;
                    state_next = ISSUE;
                    if (pick_winner == REQ_CORE) begin
                        we_next    = core_we;
                        addr_next  = core_addr;
                        wdata_next = core_wdata;
                    end else begin
                        we_next    = dbg_we;
                        addr_next  = dbg_addr;
                        wdata_next = dbg_wdata;
                    end
                end
            end
            ISSUE: begin
                cnt_next = LAT_LOAD;
                if (LAT_LOAD == '0) begin
                    capture    = 1'b1;
                    state_next = DONE;
                end else begin
                    state_next = WAIT;
                end
            end
            WAIT: begin
                cnt_next = cnt_reg - 1'b1;
                if (cnt_reg <= 1) begin
                    capture    = 1'b1;
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        // Writes leave the requester's last read value untouched.
        if (capture && !we_reg) begin
            if (grant_reg == REQ_CORE) core_rdata_next = mem_rdata;
            else                       dbg_rdata_next  = mem_rdata;
        end
    end

    always_comb begin
        stall_next = stall_reg;
        if (core_req && !core_ack && (stall_reg != 32'hFFFF_FFFF)) begin
            stall_next = stall_reg + 32'd1;
        end
        // Registered so that halted drops exactly one cycle after halt_req does.
        halted_next = halt_req && ((state_next == IDLE) || (grant_next == REQ_DBG));
    end

    assign mem_en     = (state_reg == ISSUE);
    assign mem_we     = mem_en & we_reg;
    assign mem_addr   = mem_en ? addr_reg  : '0;
    assign mem_wdata  = mem_en ? wdata_reg : '0;
    assign core_ack   = (state_reg == DONE) && (grant_reg == REQ_CORE);
    assign dbg_ack    = (state_reg == DONE) && (grant_reg == REQ_DBG);
    assign core_rdata = core_rdata_reg;
    assign dbg_rdata  = dbg_rdata_reg;
    assign stall_cnt  = stall_reg;
    assign halted     = halted_reg;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus random single and
// contested accesses checked against a transaction-level model and a behavioural memory.
module tb_mem_arbiter;

    localparam int L  = 3;
    localparam int AW = 32;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic          core_req, core_we, dbg_req, dbg_we, halt_req;
    logic [AW-1:0] core_addr, dbg_addr;
    logic [DW-1:0] core_wdata, dbg_wdata;
    logic          core_ack, dbg_ack, halted;
    logic [DW-1:0] core_rdata, dbg_rdata;
    logic          mem_en, mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;
    logic [31:0]   stall_cnt;

    mem_arbiter #(.MEM_LAT(L), .AW(AW), .DW(DW)) dut (
        .clk        (clk),
        .reset      (reset),
        .core_req   (core_req),
        .core_we    (core_we),
        .core_addr  (core_addr),
        .core_wdata (core_wdata),
        .core_ack   (core_ack),
        .core_rdata (core_rdata),
        .dbg_req    (dbg_req),
        .dbg_we     (dbg_we),
        .dbg_addr   (dbg_addr),
        .dbg_wdata  (dbg_wdata),
        .dbg_ack    (dbg_ack),
        .dbg_rdata  (dbg_rdata),
        .halt_req   (halt_req),
        .halted     (halted),
        .mem_en     (mem_en),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .stall_cnt  (stall_cnt)
    );

    always #5 clk = ~clk;

    // Behavioural memory: word array, read data held until the next read.
    logic [31:0] tb_mem [0:255];
    logic [31:0] hold = '0;
    always @(posedge clk) begin
        if (mem_en && mem_we)  tb_mem[mem_addr[9:2]] = mem_wdata;
        if (mem_en && !mem_we) hold <= tb_mem[mem_addr[9:2]];
    end
    assign mem_rdata = (mem_en && !mem_we) ? tb_mem[mem_addr[9:2]] : hold;

    // Transaction-level reference state.
    logic [31:0] ref_mem [0:255];
    int          total = 0;
    int          bad   = 0;
    int          txn   = 0;
    logic [31:0] exp_stall = '0;
    logic [31:0] exp_crd   = '0;
    logic [31:0] exp_drd   = '0;
    bit          last_dbg  = 1'b1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic got, input logic exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s observed=%b expected=%b", tag, got, exp);
        end
    endtask

    // One access, or a contested pair, started from IDLE at a negedge.
    task automatic run(input bit c_on, input bit c_we, input logic [31:0] c_addr, input logic [31:0] c_wd,
                       input bit d_on, input bit d_we, input logic [31:0] d_addr, input logic [31:0] d_wd);
        bit          core_first;
        int          c_n, d_n, last_n;
        logic        e_en, e_we;
        logic [31:0] e_addr, e_wd;
        core_first = c_on && (!d_on || last_dbg);
        c_n = 0;
        d_n = 0;
        if (c_on) c_n = core_first ? L + 1 : 2 * L + 3;
        if (d_on) d_n = (c_on && core_first) ? 2 * L + 3 : L + 1;
        last_n = (c_n > d_n) ? c_n : d_n;
        core_req = c_on; core_we = c_we; core_addr = c_addr; core_wdata = c_wd;
        dbg_req  = d_on; dbg_we  = d_we; dbg_addr  = d_addr; dbg_wdata  = d_wd;
        for (int n = 1; n <= last_n; n++) begin
            @(negedge clk);
            e_en = 1'b0; e_we = 1'b0; e_addr = '0; e_wd = '0;
            if ((n == 1) || (c_on && d_on && n == L + 3)) begin
                e_en = 1'b1;
                if ((n == 1) == core_first) begin
                    e_we = c_we; e_addr = c_addr; e_wd = c_wd;
                end else begin
                    e_we = d_we; e_addr = d_addr; e_wd = d_wd;
                end
            end
            chk1("mem_en", mem_en, e_en);
            chk1("mem_we", mem_we, e_we);
            chk("mem_addr", mem_addr, e_addr);
            chk("mem_wdata", mem_wdata, e_wd);
            chk1("core_ack", core_ack, c_on && n == c_n);
            chk1("dbg_ack", dbg_ack, d_on && n == d_n);
            if (c_on && n == c_n) begin
                if (c_we) ref_mem[c_addr[9:2]] = c_wd;
                else      exp_crd = ref_mem[c_addr[9:2]];
                chk("core_rdata", core_rdata, exp_crd);
                chk("dbg_rdata_at_core_ack", dbg_rdata, exp_drd);
                core_req = 1'b0;
            end
            if (d_on && n == d_n) begin
                if (d_we) ref_mem[d_addr[9:2]] = d_wd;
                else      exp_drd = ref_mem[d_addr[9:2]];
                chk("dbg_rdata", dbg_rdata, exp_drd);
                chk("core_rdata_at_dbg_ack", core_rdata, exp_crd);
                dbg_req = 1'b0;
            end
        end
        exp_stall = exp_stall + 32'(c_n);
        chk("stall_cnt", stall_cnt, exp_stall);
        chk1("halted_idle", halted, 1'b0);
        if (c_on && d_on) last_dbg = core_first;
        else if (c_on)    last_dbg = 1'b0;
        else if (d_on)    last_dbg = 1'b1;
        txn++;
        $display("txn %0d core(on=%0d we=%0d a=%h) dbg(on=%0d we=%0d a=%h) core_ack@%0d dbg_ack@%0d stall=%0d",
                 txn, c_on, c_we, c_addr, d_on, d_we, d_addr, c_n, d_n, stall_cnt);
        @(negedge clk);
    endtask

    task automatic chk_reset_values();
        chk1("rst_mem_en", mem_en, 1'b0);
        chk("rst_mem_addr", mem_addr, '0);
        chk1("rst_core_ack", core_ack, 1'b0);
        chk1("rst_dbg_ack", dbg_ack, 1'b0);
        chk1("rst_halted", halted, 1'b0);
        chk("rst_stall", stall_cnt, '0);
        chk("rst_core_rdata", core_rdata, '0);
        chk("rst_dbg_rdata", dbg_rdata, '0);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            tb_mem[i]  = 32'h1000_0000 + 32'(i) * 32'h0000_0101;
            ref_mem[i] = 32'h1000_0000 + 32'(i) * 32'h0000_0101;
        end
        tb_mem[64]  = 32'hDEAD_BEEF;
        ref_mem[64] = 32'hDEAD_BEEF;

        reset = 1'b0; halt_req = 1'b0;
        core_req = 1'b0; core_we = 1'b0; core_addr = '0; core_wdata = '0;
        dbg_req  = 1'b0; dbg_we  = 1'b0; dbg_addr  = '0; dbg_wdata  = '0;
        repeat (3) @(negedge clk);
        chk_reset_values();

        // Contested out of reset: core must win first.
        reset = 1'b1;
        run(1, 0, 32'h100, 32'h0, 1, 0, 32'h40, 32'h0);
        chk("stall_after_contest", stall_cnt, 32'd4);

        run(1, 0, 32'h100, 32'h0, 0, 0, 32'h0, 32'h0);
        chk("core_read_deadbeef", core_rdata, 32'hDEAD_BEEF);

        // Debug write then core read of the same word.
        run(0, 0, 32'h0, 32'h0, 1, 1, 32'h40, 32'h5A);
        run(1, 0, 32'h40, 32'h0, 0, 0, 32'h0, 32'h0);
        chk("core_reads_dbg_write", core_rdata, 32'h5A);

        for (int i = 0; i < 24; i++) begin
            int mode;
            mode = int'($urandom_range(0, 2));
            run(mode != 1, 1'($urandom_range(0, 1)), 32'($urandom_range(0, 15)) << 2, $urandom,
                mode != 0, 1'($urandom_range(0, 1)), 32'($urandom_range(0, 15)) << 2, $urandom);
        end

        // Halt raised mid-access: the core access still completes.
        core_req = 1'b1; core_we = 1'b0; core_addr = 32'h8;
        for (int n = 1; n <= L + 2; n++) begin
            @(negedge clk);
            if (n == 2) halt_req = 1'b1;
            if (n == L + 1) begin
                exp_crd = ref_mem[2];
                chk1("halt_core_ack", core_ack, 1'b1);
                chk("halt_core_rdata", core_rdata, exp_crd);
                chk1("halted_in_core_done", halted, 1'b0);
                core_req = 1'b0;
            end
        end
        chk1("halted_after_done", halted, 1'b1);
        exp_stall = exp_stall + 32'(L + 1);

        // Core blocked for 10 cycles while debug is served.
        core_req = 1'b1; core_addr = 32'hC;
        dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 32'h20; dbg_wdata = 32'hCAFE_0123;
        for (int n = 1; n <= 10; n++) begin
            @(negedge clk);
            chk1("halt_no_core_ack", core_ack, 1'b0);
            chk1("halt_halted", halted, 1'b1);
            chk1("halt_mem_en", mem_en, n == 1);
            if (n == 1) chk("halt_dbg_addr", mem_addr, 32'h20);
            chk1("halt_dbg_ack", dbg_ack, n == L + 1);
            if (n == L + 1) begin
                ref_mem[8] = 32'hCAFE_0123;
                dbg_req = 1'b0;
            end
        end
        core_req = 1'b0; halt_req = 1'b0;
        exp_stall = exp_stall + 32'd10;
        last_dbg = 1'b1;
        @(negedge clk);
        chk1("halted_falls", halted, 1'b0);
        chk("halt_stall", stall_cnt, exp_stall);
        chk1("halt_release_idle", mem_en, 1'b0);
        @(negedge clk);
        run(1, 0, 32'h20, 32'h0, 0, 0, 32'h0, 32'h0);

        // Reset during WAIT aborts the access.
        core_req = 1'b1; core_we = 1'b0; core_addr = 32'h100;
        repeat (2) @(negedge clk);
        reset = 1'b0; core_req = 1'b0;
        @(negedge clk);
        chk_reset_values();
        reset = 1'b1;
        exp_stall = '0; exp_crd = '0; exp_drd = '0; last_dbg = 1'b1;
        for (int n = 0; n < 4; n++) begin
            @(negedge clk);
            chk1("no_ack_after_abort", core_ack, 1'b0);
        end
        run(1, 0, 32'h100, 32'h0, 0, 0, 32'h0, 32'h0);
        chk("fresh_read_after_reset", core_rdata, 32'hDEAD_BEEF);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameters: MEM_LAT, 1, memory read latency in cycles (legal 1..4).
REQ-002 SHALL have parameters: AW, 32, address width; DW, 32, data width.
REQ-003 SHALL have ports: clk  in  1  sole clock; all state changes on rising edge.
REQ-004 SHALL have ports: reset  in  1  reset, synchronous and active-low.
REQ-005 SHALL have ports: core_req  in  1, core_we  in  1, core_addr  in  AW, core_wdata  in  DW: core access request.
REQ-006 SHALL have ports: core_ack  out  1  completion pulse; core_rdata  out  DW  read data.
REQ-007 SHALL have ports: dbg_req  in  1, dbg_we  in  1, dbg_addr  in  AW, dbg_wdata  in  DW: debug/loader access request.
REQ-008 SHALL have ports: dbg_ack  out  1  completion pulse; dbg_rdata  out  DW  read data.
REQ-009 SHALL have ports: halt_req  in  1  block new core grants; halted  out  1  core quiesced.
REQ-010 SHALL have ports: mem_en  out  1, mem_we  out  1, mem_addr  out  AW, mem_wdata  out  DW, mem_rdata  in  DW: single-port memory.
REQ-011 SHALL have ports: stall_cnt  out  32  cycles the core waited.

Function
REQ-012 SHALL implement the FSM states IDLE, ISSUE, WAIT and DONE.
REQ-013 IDLE: an eligible request is sampled and the winner's we/addr/wdata are latched; next state is ISSUE; with no eligible request, stay in IDLE.
REQ-014 ISSUE: mem_en=1 for exactly one cycle, driven from the latched fields; load the latency counter with MEM_LAT-1; next state is WAIT, or DONE when MEM_LAT=1.
REQ-015 WAIT: decrement the counter; when it reaches 0, capture mem_rdata and go to DONE.
REQ-016 DONE: the granted requester's ack=1 for one cycle; next state is IDLE.
REQ-017 Latency: a request sampled in IDLE at edge k SHALL produce its ack in cycle k+MEM_LAT+1, so the minimum interval between accesses is MEM_LAT+2 cycles.
REQ-018 Arbitration: with both requesters eligible, the one not granted last SHALL win (two-way round robin); with one eligible, it wins regardless.
REQ-019 Core eligibility: core_req=1 and halt_req=0.
REQ-020 Debug eligibility: dbg_req=1.
REQ-021 A grant SHALL be non-preemptive: halt_req or the other requester's req SHALL NOT abort an access in progress.
REQ-022 Requesters hold req and their fields stable until ack; the arbiter SHALL ignore field changes after latching.
REQ-023 Writes follow the same timing; for a write, rdata SHALL retain its previous value.
REQ-024 core_rdata and dbg_rdata SHALL each hold their last captured read value until that requester's next read completes.
REQ-025 mem_we, mem_addr and mem_wdata SHALL be 0 whenever mem_en=0.
REQ-026 halted=1 SHALL be asserted iff halt_req=1 and the FSM is in IDLE, or the current grant is the debug requester.
REQ-027 halted SHALL fall the cycle after halt_req falls.
REQ-028 stall_cnt SHALL increment each cycle core_req=1 and core_ack=0, and SHALL saturate at 0xFFFF_FFFF.
REQ-029 A simultaneous deassertion of req during DONE SHALL be legal; a requester re-asserting req in the cycle after its ack SHALL be treated as a new request.

Reset
REQ-030 While reset=0 at a clock edge: state=IDLE, mem_en=0, core_ack=0, dbg_ack=0, counter=0, stall_cnt=0, core_rdata=0, dbg_rdata=0, halted=0.
REQ-031 On reset, last-grant SHALL be set to debug so the core wins the first contested arbitration.
REQ-032 A reset during ISSUE, WAIT or DONE SHALL abort the access with no ack issued.

Structure
REQ-033 Package mem_arb_pkg SHALL hold the state enum (IDLE, ISSUE, WAIT, DONE), the requester enum (REQ_CORE, REQ_DBG) and the MEM_LAT legal-range constants.
REQ-034 One sub-module is natural: rr_arb2, a combinational two-way round-robin picker taking two eligibility bits and last-grant and returning the winner.

Verification
REQ-035 MEM_LAT=1; a core read of 0x100 where memory holds 0xDEADBEEF -> mem_en in cycle k+1, core_ack in cycle k+2, core_rdata=0xDEADBEEF.
REQ-036 MEM_LAT=3; core_req and dbg_req both asserted out of reset -> core granted first, core ack in cycle k+4, debug granted next, debug ack 5 cycles later; stall_cnt=4 at the end.
REQ-037 Debug write of 0x5A to 0x40, then core read of 0x40 -> core_rdata=0x5A; dbg_rdata unchanged by the write.
REQ-038 halt_req raised during a core WAIT -> the core access completes with an ack, halted=1 the cycle after DONE; a core_req held for 10 cycles -> no grant and stall_cnt +10; a debug request meanwhile is served.
REQ-039 reset driven low in WAIT -> no ack issued, mem_en=0, all outputs at reset values next cycle; a fresh core request afterwards completes normally.
